// File: rtl/x25519_pkg.sv
// Shared types for the X25519 Montgomery-ladder sequencer: micro-op encoding,
// register-file map and the fixed 19-slot ladder schedule.
package x25519_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_MUL   = 2'd2,
    OP_CSWAP = 2'd3
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  localparam logic [3:0] R_X1  = 4'd0;
  localparam logic [3:0] R_X2  = 4'd1;
  localparam logic [3:0] R_Z2  = 4'd2;
  localparam logic [3:0] R_X3  = 4'd3;
  localparam logic [3:0] R_Z3  = 4'd4;
  localparam logic [3:0] R_A24 = 4'd5;
  localparam logic [3:0] R_A   = 4'd6;
  localparam logic [3:0] R_AA  = 4'd7;
  localparam logic [3:0] R_B   = 4'd8;
  localparam logic [3:0] R_BB  = 4'd9;
  localparam logic [3:0] R_E   = 4'd10;
  localparam logic [3:0] R_C   = 4'd11;
  localparam logic [3:0] R_D   = 4'd12;
  localparam logic [3:0] R_DA  = 4'd13;
  localparam logic [3:0] R_CB  = 4'd14;
  localparam logic [3:0] R_T   = 4'd15;

  localparam int LADDER_SLOTS = 19;

  typedef struct packed {
    op_code_e   code;
    logic [3:0] dst;
    logic [3:0] a;
    logic [3:0] b;
  } ladder_uop_t;

  // Slot 0 is the CSWAP; the sequencer drives its operands from the live swap flag.
  localparam ladder_uop_t LADDER_SCHEDULE [LADDER_SLOTS] = '{
    '{OP_CSWAP, R_X1,  R_X1,  R_X1},
    '{OP_ADD,   R_A,   R_X2,  R_Z2},
    '{OP_MUL,   R_AA,  R_A,   R_A},
    '{OP_SUB,   R_B,   R_X2,  R_Z2},
    '{OP_MUL,   R_BB,  R_B,   R_B},
    '{OP_SUB,   R_E,   R_AA,  R_BB},
    '{OP_ADD,   R_C,   R_X3,  R_Z3},
    '{OP_SUB,   R_D,   R_X3,  R_Z3},
    '{OP_MUL,   R_DA,  R_D,   R_A},
    '{OP_MUL,   R_CB,  R_C,   R_B},
    '{OP_ADD,   R_T,   R_DA,  R_CB},
    '{OP_MUL,   R_X3,  R_T,   R_T},
    '{OP_SUB,   R_T,   R_DA,  R_CB},
    '{OP_MUL,   R_T,   R_T,   R_T},
    '{OP_MUL,   R_Z3,  R_X1,  R_T},
    '{OP_MUL,   R_X2,  R_AA,  R_BB},
    '{OP_MUL,   R_T,   R_A24, R_E},
    '{OP_ADD,   R_T,   R_AA,  R_T},
    '{OP_MUL,   R_Z2,  R_E,   R_T}
  };

endpackage

// File: rtl/x25519_ladder_rom.sv
// Combinational slot -> micro-op lookup over the ladder schedule; slots past
// the end of the schedule decode to an all-zero op.
module x25519_ladder_rom
  import x25519_pkg::*;
(
  input  logic [4:0]  slot,
  output ladder_uop_t uop
);

  always_comb begin
    uop = '0;
    if (slot < 5'(LADDER_SLOTS)) uop = LADDER_SCHEDULE[slot];
  end

endmodule

// File: rtl/x25519_ladder_sequencer.sv
// Montgomery-ladder micro-op sequencer for X25519. Optional build macro
// X25519_CLAMP_EN clamps the latched scalar as RFC 7748 decodeScalar does.
module x25519_ladder_sequencer
  import x25519_pkg::*;
#(
  parameter int SCALAR_BITS   = 255,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [SCALAR_BITS-1:0]         e,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           op_valid,
  input  logic                           op_ready,
  output logic [1:0]                     op_code,
  output logic [REG_ADDR_BITS-1:0]       op_dst,
  output logic [REG_ADDR_BITS-1:0]       op_a,
  output logic [REG_ADDR_BITS-1:0]       op_b,
  output logic [$clog2(SCALAR_BITS)-1:0] bit_index,
  output logic [1:0]                     state_dbg
);

  localparam int IDX_W = $clog2(SCALAR_BITS);
  localparam logic [4:0] LAST_SLOT = 5'(LADDER_SLOTS - 1);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(SCALAR_BITS - 1);

  state_e                 state;
  logic [SCALAR_BITS-1:0] scalar;
  logic [SCALAR_BITS-1:0] scalar_in;
  logic                   swap;
  logic [4:0]             slot;
  logic [4:0]             next_slot;
  logic [IDX_W-1:0]       idx_dn;
  ladder_uop_t            next_uop;
  logic                   xfer;

  // Handshake: an op transfers on a cycle with op_valid && op_ready; while
  // op_valid is high and op_ready low the op fields are held unchanged, and the
  // following op is presented on the cycle right after a transfer.
  assign xfer      = op_valid && op_ready;
  assign next_slot = (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
  assign idx_dn    = bit_index - 1'b1;
  assign state_dbg = state;

`ifdef X25519_CLAMP_EN
  function automatic logic [SCALAR_BITS-1:0] clamp_scalar(input logic [SCALAR_BITS-1:0] k);
    logic [SCALAR_BITS-1:0] r;
    r = k;
    for (int i = 0; i < 3 && i < SCALAR_BITS; i++) r[i] = 1'b0;
    if (SCALAR_BITS == 256) begin
      r[SCALAR_BITS-1] = 1'b0;
      r[SCALAR_BITS-2] = 1'b1;
    end else begin
      r[SCALAR_BITS-1] = 1'b1;
    end
    return r;
  endfunction
  assign scalar_in = clamp_scalar(e);
`else
  assign scalar_in = e;
`endif

  function automatic logic [REG_ADDR_BITS-1:0] swap_arg(input logic flag);
    return {{(REG_ADDR_BITS-1){1'b0}}, flag};
  endfunction

  // Lookahead: the ROM decodes the slot that will be presented after a transfer.
  x25519_ladder_rom u_rom (
    .slot (next_slot),
    .uop  (next_uop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      scalar    <= '0;
      swap      <= 1'b0;
      slot      <= '0;
      bit_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_valid  <= 1'b0;
      op_code   <= '0;
      op_dst    <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else if (abort) begin
      state    <= ST_IDLE;
      slot     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_valid <= 1'b0;
      op_code  <= '0;
      op_dst   <= '0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            scalar    <= scalar_in;
            swap      <= 1'b0;
            bit_index <= TOP_IDX;
            slot      <= '0;
            busy      <= 1'b1;
            op_valid  <= 1'b1;
            op_code   <= OP_CSWAP;
            op_dst    <= '0;
            op_a      <= '0;
            op_b      <= swap_arg(scalar_in[SCALAR_BITS-1]);
            state     <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (xfer) begin
            if (slot == LAST_SLOT) begin
              slot    <= '0;
              op_code <= OP_CSWAP;
              op_dst  <= '0;
              op_a    <= '0;
              if (bit_index == '0) begin
                op_b  <= swap_arg(swap);
                state <= ST_FINAL;
              end else begin
                bit_index <= idx_dn;
                op_b      <= swap_arg(swap ^ scalar[idx_dn]);
              end
            end else begin
              // swap tracks the bit whose CSWAP has just been issued.
              if (slot == '0) swap <= scalar[bit_index];
              slot    <= next_slot;
              op_code <= next_uop.code;
              op_dst  <= REG_ADDR_BITS'(next_uop.dst);
              op_a    <= REG_ADDR_BITS'(next_uop.a);
              op_b    <= REG_ADDR_BITS'(next_uop.b);
            end
          end
        end
        ST_FINAL: begin
          if (xfer) begin
            op_valid <= 1'b0;
            done     <= 1'b1;
            op_code  <= '0;
            op_b     <= '0;
          end else if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// Directed bench for x25519_ladder_sequencer with SCALAR_BITS=4; honours
// X25519_CLAMP_EN when choosing the expected swap flags for a zero scalar.
module tb_x25519_ladder_sequencer;

  localparam int SB = 4;
  localparam int RB = 4;
  localparam int W  = 14;

`ifdef X25519_CLAMP_EN
  localparam logic [3:0] ZERO_FLAGS = 4'b1100;
`else
  localparam logic [3:0] ZERO_FLAGS = 4'b0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [SB-1:0] e;
  logic          abort;
  logic          busy;
  logic          done;
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_code;
  logic [RB-1:0] op_dst;
  logic [RB-1:0] op_a;
  logic [RB-1:0] op_b;
  logic [1:0]    bit_index;
  logic [1:0]    state_dbg;
  logic [W-1:0]  op_word;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           xfer_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sched [18];
  logic         held_v = 1'b0;
  logic [W-1:0] held_w = '0;

  assign op_word = {op_code, op_dst, op_a, op_b};

  x25519_ladder_sequencer #(.SCALAR_BITS(SB), .REG_ADDR_BITS(RB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .e         (e),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_dst    (op_dst),
    .op_a      (op_a),
    .op_b      (op_b),
    .bit_index (bit_index),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] uw(input int code, input int d, input int a, input int b);
    return {2'(code), 4'(d), 4'(a), 4'(b)};
  endfunction

  function automatic logic [W-1:0] cswap_w(input logic flag);
    return {2'd3, 4'd0, 4'd0, 3'd0, flag};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic build_expected(input logic [3:0] flags, input logic final_flag);
    exp_q.delete();
    for (int b = 3; b >= 0; b--) begin
      exp_q.push_back(cswap_w(flags[b]));
      for (int s = 0; s < 18; s++) exp_q.push_back(sched[s]);
    end
    exp_q.push_back(cswap_w(final_flag));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && op_valid) check_eq("stall_stable", op_word, held_w);
      held_v = op_valid && !op_ready && !abort;
      held_w = op_word;
      if (op_valid && op_ready && !abort) begin
        xfer_cnt++;
        if (exp_q.size() > 0) check_eq($sformatf("op_%0d", xfer_cnt), op_word, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0 (en asserted).
  task automatic run_ladder(input string name, input logic [3:0] ev, input logic [3:0] flags,
                            input bit toggle, input int abort_c, input int en2_c,
                            input int rst_c, input int exp_done);
    int   c;
    int   done_c;
    bit   stop;
    logic seen;
    build_expected(flags, 1'b0);
    xfer_cnt = 0;
    done_c   = -1;
    stop     = 1'b0;
    c        = 0;
    e        = ev;
    en       = 1'b1;
    op_ready = 1'b1;
    while (!stop && c < 400) begin
      @(posedge clk);
      #1;
      c++;
      en    = 1'b0;
      abort = 1'b0;
      if (toggle) op_ready = (c % 2 == 0);
      if (c == 1) begin
        check_eq({name, "_valid_c1"}, op_valid, 1);
        check_eq({name, "_bitidx_c1"}, bit_index, 3);
      end
      if (c == 2 && !toggle) check_eq({name, "_slot1"}, op_word, uw(0, 6, 1, 2));
      if (c == en2_c) begin
        en = 1'b1;
        e  = ~ev;
      end
      if (c == abort_c) abort = 1'b1;
      if (abort_c > 0 && c == abort_c + 1) begin
        check_eq({name, "_abort_next"}, {op_valid, busy, done}, 0);
        stop = 1'b1;
      end
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        check_eq({name, "_async_rst"}, {busy, done, op_valid, op_word, bit_index, state_dbg}, 0);
        tick(3);
        rst_n = 1'b1;
        stop  = 1'b1;
      end
      if (done && done_c < 0) done_c = c;
      if (done_c >= 0 && c == done_c + 1) begin
        check_eq({name, "_end"}, {busy, done}, 0);
        stop = 1'b1;
      end
    end
    check_eq({name, "_bounded"}, stop, 1);
    if (abort_c > 0) begin
      seen = 1'b0;
      repeat (3) begin
        tick(1);
        seen |= done | op_valid | busy;
      end
      check_eq({name, "_abort_quiet"}, seen, 0);
      check_eq({name, "_abort_xfers"}, xfer_cnt, abort_c - 1);
    end else if (rst_c > 0) begin
      check_eq({name, "_rst_xfers"}, xfer_cnt, rst_c - 1);
    end else begin
      check_eq({name, "_done_cycle"}, done_c, exp_done);
      check_eq({name, "_xfers"}, xfer_cnt, 77);
      check_eq({name, "_queue_empty"}, exp_q.size(), 0);
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sched = '{uw(0, 6, 1, 2),    uw(2, 7, 6, 6),    uw(1, 8, 1, 2),    uw(2, 9, 8, 8),
              uw(1, 10, 7, 9),   uw(0, 11, 3, 4),   uw(1, 12, 3, 4),   uw(2, 13, 12, 6),
              uw(2, 14, 11, 8),  uw(0, 15, 13, 14), uw(2, 3, 15, 15),  uw(1, 15, 13, 14),
              uw(2, 15, 15, 15), uw(2, 4, 0, 15),   uw(2, 1, 7, 9),    uw(2, 15, 5, 10),
              uw(0, 15, 7, 15),  uw(2, 2, 10, 15)};
    rst_n    = 1'b0;
    en       = 1'b0;
    abort    = 1'b0;
    op_ready = 1'b0;
    e        = '0;
    tick(2);
    check_eq("reset_state", {busy, done, op_valid, op_word, bit_index, state_dbg}, 0);
    rst_n = 1'b1;
    tick(2);
    check_eq("idle_quiet", {busy, done, op_valid}, 0);

    run_ladder("s1_basic", 4'b1010, 4'b1111, 1'b0, -1, -1, -1, 78);
    tick(2);
    run_ladder("s2_backpressure", 4'b1010, 4'b1111, 1'b1, -1, -1, -1, 155);
    tick(2);
    run_ladder("s3_abort", 4'b1010, 4'b1111, 1'b0, 30, -1, -1, 0);
    run_ladder("s3_restart", 4'b1010, 4'b1111, 1'b0, -1, -1, -1, 78);
    tick(2);
    run_ladder("s4_en_busy", 4'b1010, 4'b1111, 1'b0, -1, 20, -1, 78);
    tick(2);
    run_ladder("s5_reset", 4'b1010, 4'b1111, 1'b0, -1, -1, 40, 0);
    tick(2);
    run_ladder("s5_rerun", 4'b1010, 4'b1111, 1'b0, -1, -1, -1, 78);
    tick(2);
    run_ladder("s6_zero", 4'b0000, ZERO_FLAGS, 1'b0, -1, -1, -1, 78);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
